// File: rtl/mmio_responder_pkg.sv
// Shared definitions for the 0x8xxx_xxxx I/O window responder: region nibble,
// register offsets, TX state encoding and the STATUS word layout.
package mmio_responder_pkg;

    localparam logic [3:0] IO_REGION  = 4'b1000;

    localparam logic [7:0] IO_STATUS  = 8'h00;
    localparam logic [7:0] IO_RXDATA  = 8'h04;
    localparam logic [7:0] IO_TXDATA  = 8'h08;
    localparam logic [7:0] IO_CYCLES  = 8'h10;
    localparam logic [7:0] IO_INSTRET = 8'h14;
    localparam logic [7:0] IO_CNTCLR  = 8'h18;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_e;

    function automatic logic [31:0] status_word(input logic tx_ovf,
                                                input logic rx_valid,
                                                input logic tx_ready);
        return {29'b0, tx_ovf, rx_valid, tx_ready};
    endfunction

endpackage

// File: rtl/mmio_rx_fifo.sv
// Power-of-two RX byte FIFO; head entry is visible on pop_data while not empty.
// Pushes when full and pops when empty are ignored.
module mmio_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// I/O window responder: UART TX/RX, cycle and retired-instruction counters.
// Define MMIO_RX_FIFO_EN for a RX_FIFO_DEPTH-entry RX FIFO; otherwise one holding byte.
module mmio_responder
    import mmio_responder_pkg::*;
#(
    parameter int RX_FIFO_DEPTH = 8,
    parameter int CNT_W         = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_addr,
    input  logic [3:0]  io_trans,
    input  logic        io_recv,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    input  logic        instr_retire,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    logic [7:0] reg_off;
    logic       io_hit;
    logic       store_en;
    logic       load_en;
    logic       tx_store;
    logic       ovf_clr;
    logic       cnt_clr;
    logic       rx_pop_req;

    assign reg_off    = io_addr[7:0];
    assign io_hit     = (io_addr[31:28] == IO_REGION);
    assign store_en   = io_hit && (io_trans != 4'b0000);
    // A store seen together with a load takes precedence; the load is dropped.
    assign load_en    = io_hit && io_recv && !store_en;
    assign tx_store   = store_en && (reg_off == IO_TXDATA) && io_trans[0];
    assign ovf_clr    = store_en && (reg_off == IO_STATUS) && io_wdata[2];
    assign cnt_clr    = store_en && (reg_off == IO_CNTCLR);
    assign rx_pop_req = load_en && (reg_off == IO_RXDATA);

    logic       rx_push;
    logic       rx_pop;
    logic       rx_full;
    logic       rx_nonempty;
    logic [7:0] rx_head;
    logic       unused_ok;

    assign uart_rx_ready = !rx_full;
    assign rx_push       = uart_rx_valid && !rx_full;
    assign rx_pop        = rx_pop_req && rx_nonempty;

`ifdef MMIO_RX_FIFO_EN
    logic rx_empty;

    mmio_rx_fifo #(
        .DEPTH (RX_FIFO_DEPTH),
        .W     (8)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (uart_rx_data),
        .pop       (rx_pop),
        .pop_data  (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    assign rx_nonempty = !rx_empty;
    assign unused_ok   = ^{io_addr[27:8], io_wdata[31:8]};
`else
    localparam logic [31:0] RX_DEPTH_BITS = 32'(RX_FIFO_DEPTH);

    logic       rx_full_q, rx_full_d;
    logic [7:0] rx_byte_q, rx_byte_d;

    // Ready is low while holding, so capture and pop never coincide here.
    always_comb begin
        rx_full_d = rx_full_q;
        rx_byte_d = rx_byte_q;
        if (rx_push) begin
            rx_full_d = 1'b1;
            rx_byte_d = uart_rx_data;
        end else if (rx_pop) begin
            rx_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_full_q <= 1'b0;
            rx_byte_q <= 8'h00;
        end else begin
            rx_full_q <= rx_full_d;
            rx_byte_q <= rx_byte_d;
        end
    end

    assign rx_full     = rx_full_q;
    assign rx_nonempty = rx_full_q;
    assign rx_head     = rx_byte_q;
    assign unused_ok   = ^{io_addr[27:8], io_wdata[31:8], RX_DEPTH_BITS};
`endif

    tx_state_e  tx_state_q, tx_state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_ovf_q, tx_ovf_d;
    logic       tx_hs;

    assign tx_hs         = (tx_state_q == TX_BUSY) && uart_tx_ready;
    assign uart_tx_valid = (tx_state_q == TX_BUSY);
    assign uart_tx_data  = tx_data_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        tx_ovf_d   = tx_ovf_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_store) begin
                    tx_state_d = TX_BUSY;
                    tx_data_d  = io_wdata[7:0];
                end
            end
            TX_BUSY: begin
                // A store landing on the handshake cycle refills the slot directly.
                if (tx_hs) begin
                    if (tx_store) begin
                        tx_data_d = io_wdata[7:0];
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else if (tx_store) begin
                    tx_ovf_d = 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        if (ovf_clr) begin
            tx_ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_data_q  <= 8'h00;
            tx_ovf_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_data_q  <= tx_data_d;
            tx_ovf_q   <= tx_ovf_d;
        end
    end

    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    always_comb begin
        cycles_d  = cycles_q + CNT_W'(1);
        instret_d = instret_q + CNT_W'(instr_retire);
        if (cnt_clr) begin
            cycles_d  = '0;
            instret_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles_q  <= '0;
            instret_q <= '0;
        end else begin
            cycles_q  <= cycles_d;
            instret_q <= instret_d;
        end
    end

    logic [31:0] rd_word;
    logic [31:0] io_rdata_q, io_rdata_d;

    always_comb begin
        rd_word = 32'h0;
        case (reg_off)
            IO_STATUS:  rd_word = status_word(tx_ovf_q, rx_nonempty, tx_state_q == TX_IDLE);
            IO_RXDATA:  rd_word = {24'h0, rx_nonempty ? rx_head : 8'h00};
            IO_CYCLES:  rd_word = 32'(cycles_q);
            IO_INSTRET: rd_word = 32'(instret_q);
            default:    rd_word = 32'h0;
        endcase
        io_rdata_d = load_en ? rd_word : io_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_rdata_q <= 32'h0;
        end else begin
            io_rdata_q <= io_rdata_d;
        end
    end

    assign io_rdata = io_rdata_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed table, corner sequences and
// random traffic compared each cycle against a queue-based reference model.
module tb_mmio_responder;

    localparam int CNT_W = 10;
    localparam int DEPTH = 8;
`ifdef MMIO_RX_FIFO_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] io_addr;
    logic [3:0]  io_trans;
    logic        io_recv;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        instr_retire;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;

    always #5 clk = ~clk;

    mmio_responder #(
        .RX_FIFO_DEPTH (DEPTH),
        .CNT_W         (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .io_addr       (io_addr),
        .io_trans      (io_trans),
        .io_recv       (io_recv),
        .io_wdata      (io_wdata),
        .io_rdata      (io_rdata),
        .instr_retire  (instr_retire),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the window seen as a byte queue, a TX slot and two counters.
    int          m_cyc;
    int          m_ins;
    byte         m_rxq[$];
    bit          m_busy;
    logic [7:0]  m_txb;
    bit          m_ovf;
    logic [31:0] m_rdata;
    bit          t_st;
    bit          t_ld;
    bit          t_push;
    logic [7:0]  t_a;
    logic [31:0] t_rv;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc   = 0;
            m_ins   = 0;
            m_rxq.delete();
            m_busy  = 0;
            m_txb   = 8'h00;
            m_ovf   = 0;
            m_rdata = 32'h0;
        end else begin
            t_st   = (io_trans != 4'h0);
            t_ld   = io_recv && !t_st;
            t_a    = io_addr[7:0];
            t_push = uart_rx_valid && (m_rxq.size() < CAP);
            if (t_ld) begin
                t_rv = 32'h0;
                case (t_a)
                    8'h00: t_rv = {29'd0, m_ovf, m_rxq.size() != 0, !m_busy};
                    8'h04: if (m_rxq.size() != 0) t_rv = {24'd0, m_rxq.pop_front()};
                    8'h10: t_rv = 32'(m_cyc);
                    8'h14: t_rv = 32'(m_ins);
                    default: t_rv = 32'h0;
                endcase
                m_rdata = t_rv;
            end
            if (t_push) m_rxq.push_back(uart_rx_data);
            if (m_busy && uart_tx_ready) m_busy = 0;
            if (t_st && t_a == 8'h08 && io_trans[0]) begin
                if (m_busy) begin
                    m_ovf = 1;
                end else begin
                    m_busy = 1;
                    m_txb  = io_wdata[7:0];
                end
            end
            if (t_st && t_a == 8'h00 && io_wdata[2]) m_ovf = 0;
            if (t_st && t_a == 8'h18) begin
                m_cyc = 0;
                m_ins = 0;
            end else begin
                m_cyc = (m_cyc + 1) % (1 << CNT_W);
                m_ins = (m_ins + int'(instr_retire)) % (1 << CNT_W);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("model_rdata", io_rdata, m_rdata);
        chk("model_tx_valid", 32'(uart_tx_valid), 32'(m_busy));
        chk("model_tx_data", 32'(uart_tx_data), 32'(m_txb));
        chk("model_rx_ready", 32'(uart_rx_ready), 32'(m_rxq.size() < CAP));
    endtask

    task automatic drive(input logic [3:0] tr, input logic [7:0] off, input logic [31:0] wd,
                         input logic rv, input logic ret, input logic txr,
                         input logic rxv, input logic [7:0] rxd);
        io_trans      = tr;
        io_addr       = {24'h800000, off};
        io_wdata      = wd;
        io_recv       = rv;
        instr_retire  = ret;
        uart_tx_ready = txr;
        uart_rx_valid = rxv;
        uart_rx_data  = rxd;
    endtask

    task automatic idle();
        drive(4'h0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_rdata", io_rdata, 32'h0);
        chk("reset_tx_valid", 32'(uart_tx_valid), 32'h0);
        chk("reset_tx_data", 32'(uart_tx_data), 32'h0);
        chk("reset_rx_ready", 32'(uart_rx_ready), 32'h1);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  trans;
        logic [7:0]  off;
        logic [31:0] wdata;
        logic        recv;
        logic        txr;
        logic        rxv;
        logic [7:0]  rxd;
        logic [31:0] exp_rdata;
        logic        exp_valid;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t tbl[20];

    logic [7:0] offs[8];

    initial begin
        rst = 1'b1;
        idle();

        // Counter read latency and clear.
        do_reset();
        repeat (5) tick();
        drive(4'h0, 8'h10, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("cycles_after_5", io_rdata, 32'd5);
        drive(4'hF, 8'h18, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        drive(4'h0, 8'h10, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("cycles_after_clr", io_rdata, 32'd0);

        // Directed TX / STATUS / RX table.
        tbl[0]  = '{4'h1, 8'h08, 32'h41,  1'b0, 1'b0, 1'b0, 8'h00, 32'h0,  1'b1, 8'h41};
        tbl[1]  = '{4'h0, 8'h00, 32'h0,   1'b0, 1'b0, 1'b0, 8'h00, 32'h0,  1'b1, 8'h41};
        tbl[2]  = '{4'h0, 8'h00, 32'h0,   1'b1, 1'b0, 1'b0, 8'h00, 32'h0,  1'b1, 8'h41};
        tbl[3]  = '{4'h1, 8'h08, 32'h42,  1'b0, 1'b0, 1'b0, 8'h00, 32'h0,  1'b1, 8'h41};
        tbl[4]  = '{4'h0, 8'h00, 32'h0,   1'b1, 1'b0, 1'b0, 8'h00, 32'h4,  1'b1, 8'h41};
        tbl[5]  = '{4'hF, 8'h00, 32'h4,   1'b0, 1'b0, 1'b0, 8'h00, 32'h4,  1'b1, 8'h41};
        tbl[6]  = '{4'h0, 8'h00, 32'h0,   1'b1, 1'b0, 1'b0, 8'h00, 32'h0,  1'b1, 8'h41};
        tbl[7]  = '{4'h0, 8'h00, 32'h0,   1'b0, 1'b1, 1'b0, 8'h00, 32'h0,  1'b0, 8'h41};
        tbl[8]  = '{4'h0, 8'h00, 32'h0,   1'b1, 1'b0, 1'b0, 8'h00, 32'h1,  1'b0, 8'h41};
        tbl[9]  = '{4'h0, 8'h00, 32'h0,   1'b0, 1'b0, 1'b1, 8'h55, 32'h1,  1'b0, 8'h41};
        tbl[10] = '{4'h0, 8'h00, 32'h0,   1'b1, 1'b0, 1'b0, 8'h00, 32'h3,  1'b0, 8'h41};
        tbl[11] = '{4'h0, 8'h04, 32'h0,   1'b1, 1'b0, 1'b0, 8'h00, 32'h55, 1'b0, 8'h41};
        tbl[12] = '{4'h0, 8'h00, 32'h0,   1'b1, 1'b0, 1'b0, 8'h00, 32'h1,  1'b0, 8'h41};
        tbl[13] = '{4'h0, 8'h04, 32'h0,   1'b1, 1'b0, 1'b0, 8'h00, 32'h0,  1'b0, 8'h41};
        tbl[14] = '{4'h0, 8'h00, 32'h0,   1'b1, 1'b0, 1'b0, 8'h00, 32'h1,  1'b0, 8'h41};
        tbl[15] = '{4'h2, 8'h08, 32'h1FF, 1'b0, 1'b0, 1'b0, 8'h00, 32'h1,  1'b0, 8'h41};
        tbl[16] = '{4'h0, 8'h0C, 32'h0,   1'b1, 1'b0, 1'b0, 8'h00, 32'h0,  1'b0, 8'h41};
        tbl[17] = '{4'h0, 8'h00, 32'h0,   1'b1, 1'b0, 1'b0, 8'h00, 32'h1,  1'b0, 8'h41};
        tbl[18] = '{4'h1, 8'h08, 32'h77,  1'b1, 1'b0, 1'b0, 8'h00, 32'h1,  1'b1, 8'h77};
        tbl[19] = '{4'h0, 8'h00, 32'h0,   1'b0, 1'b1, 1'b0, 8'h00, 32'h1,  1'b0, 8'h77};

        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].trans, tbl[i].off, tbl[i].wdata, tbl[i].recv, 1'b0,
                  tbl[i].txr, tbl[i].rxv, tbl[i].rxd);
            tick();
            chk($sformatf("tbl%0d_rdata", i), io_rdata, tbl[i].exp_rdata);
            chk($sformatf("tbl%0d_tx_valid", i), 32'(uart_tx_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_tx_data", i), 32'(uart_tx_data), 32'(tbl[i].exp_data));
            $display("vec %0d: off=%h trans=%h recv=%0d rdata=%h tx_valid=%0d tx_data=%h",
                     i, tbl[i].off, tbl[i].trans, tbl[i].recv, io_rdata, uart_tx_valid, uart_tx_data);
        end

        // RX fill, blocked push when full, pop and push in one cycle, refill.
        idle();
        for (int i = 0; i < CAP + 2; i++) begin
            drive(4'h0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0 + 8'(i));
            tick();
        end
        chk("rx_full_ready", 32'(uart_rx_ready), 32'h0);
        drive(4'h0, 8'h04, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC0);
        tick();
        chk("rx_pop_oldest", io_rdata, 32'hA0);
        drive(4'h0, 8'h04, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC1);
        tick();
        chk("rx_pop_push", io_rdata, (CAP > 1) ? 32'hA1 : 32'h0);
        chk("rx_pop_push_ready", 32'(uart_rx_ready), 32'(CAP > 1));
        drive(4'h0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC2);
        tick();
        chk("rx_refull_ready", 32'(uart_rx_ready), 32'h0);
        for (int i = 0; i < CAP + 1; i++) begin
            drive(4'h0, 8'h04, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            tick();
        end
        chk("rx_drained", io_rdata, 32'h0);

        // INSTRET clear beats a same-cycle retire; CYCLES wrap.
        drive(4'hF, 8'h18, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        repeat (3) begin
            drive(4'h0, 8'h00, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            tick();
        end
        drive(4'h0, 8'h14, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("instret_3", io_rdata, 32'd3);
        drive(4'hF, 8'h18, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        drive(4'h0, 8'h14, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("instret_clr_retire", io_rdata, 32'd0);
        drive(4'hF, 8'h18, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        idle();
        repeat ((1 << CNT_W) - 1) tick();
        drive(4'h0, 8'h10, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("cycles_max", io_rdata, 32'((1 << CNT_W) - 1));
        tick();
        chk("cycles_wrap", io_rdata, 32'd0);

        // Reset in the middle of a TX transfer with RX data held.
        drive(4'h1, 8'h08, 32'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33);
        tick();
        idle();
        #2 rst = 1'b1;
        #1;
        chk("midrst_tx_valid", 32'(uart_tx_valid), 32'h0);
        chk("midrst_rx_ready", 32'(uart_rx_ready), 32'h1);
        chk("midrst_rdata", io_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Random traffic against the model.
        offs[0] = 8'h00; offs[1] = 8'h04; offs[2] = 8'h08; offs[3] = 8'h0C;
        offs[4] = 8'h10; offs[5] = 8'h14; offs[6] = 8'h18; offs[7] = 8'h1C;
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] off;
            logic [3:0] tr;
            off = offs[$urandom_range(0, 7)];
            tr  = ($urandom_range(0, 99) < 25) ? 4'($urandom_range(0, 15)) : 4'h0;
            if (off == 8'h18 && $urandom_range(0, 9) != 0) tr = 4'h0;
            drive(tr, off, $urandom(), $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom()));
            tick();
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
